// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, reads words over a req/ack handshake,
// and hands {pc, word} to the datapath from a small queue; redirect flushes and refetches.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        CLK,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instructionCode,
    output logic [31:0] inst_pc
);
    localparam int               PTR_W   = $clog2(DEPTH);
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

    state_t           r_state, w_state_nxt;
    logic [31:0]      r_fetch_pc, w_fetch_pc_nxt;
    logic [31:0]      r_req_addr, w_req_addr_nxt;
    logic [31:0]      r_q_pc   [DEPTH];
    logic [31:0]      r_q_word [DEPTH];
    logic [PTR_W-1:0] r_wptr, r_rptr;
    logic [CNT_W-1:0] r_count, w_count_nxt;
    logic             w_pop, w_push, w_space;
    logic [31:0]      w_redir_pc;

    assign w_redir_pc      = redirect_pc & 32'hFFFF_FFFC;
    assign imem_req        = (r_state != S_IDLE);
    assign imem_addr       = r_req_addr;
    assign inst_valid      = (r_count != '0);
    assign instructionCode = inst_valid ? r_q_word[r_rptr] : 32'h0;
    assign inst_pc         = inst_valid ? r_q_pc[r_rptr]   : 32'h0;

    // A request is only launched when the slot its word will need is already free.
    always_comb begin
        w_pop       = inst_valid && inst_ready;
        w_push      = (r_state == S_WAIT) && imem_ack && !redirect;
        w_count_nxt = r_count - CNT_W'(w_pop) + CNT_W'(w_push);
        w_space     = (w_count_nxt < DEPTH_C);
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_req_addr_nxt = r_req_addr;
        case (r_state)
            S_IDLE: begin
                if (redirect) begin
                    w_fetch_pc_nxt = w_redir_pc;
                end else if (w_space) begin
                    w_req_addr_nxt = r_fetch_pc;
                    w_state_nxt    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_ack) begin
                    if (redirect) begin
                        w_fetch_pc_nxt = w_redir_pc;
                        w_state_nxt    = S_IDLE;
                    end else begin
                        w_fetch_pc_nxt = r_req_addr + 32'd4;
                        if (w_space) begin
                            w_req_addr_nxt = r_req_addr + 32'd4;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end else if (redirect) begin
                    w_fetch_pc_nxt = w_redir_pc;
                    w_state_nxt    = S_DROP;
                end
            end
            S_DROP: begin
                if (redirect) begin
                    w_fetch_pc_nxt = w_redir_pc;
                end
                if (imem_ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_count    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_req_addr <= w_req_addr_nxt;
            // Flush takes priority over any pop or push in the same cycle.
            if (redirect) begin
                r_count <= '0;
                r_wptr  <= '0;
                r_rptr  <= '0;
            end else begin
                r_count <= w_count_nxt;
                if (w_push) r_wptr <= r_wptr + PTR_W'(1);
                if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_q_pc[r_wptr]   <= r_req_addr;
            r_q_word[r_wptr] <= imem_rdata;
        end
    end

endmodule
